spi_cfg_responder: RTL and testbench

- Guest-side SPI responder (mode 0, MSB first) for the configuration link driven by substitute_mcu, which acts as the initiator over SPI_SCK/SPI_DI/SPI_DO/CONF_DATA0.
- Oversamples the SPI lines in the guest system clock and decodes command/payload transactions into joystick, PS/2 keyboard, PS/2 mouse and status outputs.
- Shifts the core type byte back to the MCU.
- Sits inside guest_top next to the core.

---
 rtl/spi_cfg_responder_if.sv | 14 +
 rtl/spi_cfg_responder.sv | 207 ++++++++++++++++++++
 tb/tb_spi_cfg_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_responder_if.sv
// SPI configuration link between the MCU (initiator) and the guest responder.
//   SPI_SCK    : SPI clock from the MCU, asynchronous to the guest clock
//   SPI_DI     : MOSI, MCU -> guest
//   CONF_DATA0 : active-low transaction select
//   SPI_DO     : MISO, guest -> MCU
interface spi_cfg_responder_if;
  logic SPI_SCK;
  logic SPI_DI;
  logic CONF_DATA0;
  logic SPI_DO;

  modport master (output SPI_SCK, output SPI_DI, output CONF_DATA0, input SPI_DO);
  modport slave  (input SPI_SCK, input SPI_DI, input CONF_DATA0, output SPI_DO);
endinterface

// File: rtl/spi_cfg_responder.sv
// Guest-side SPI mode-0 responder for the MCU configuration link. The SPI lines
// are oversampled in the guest clock and decoded into command/payload
// transactions that drive joystick, PS/2 keyboard/mouse and status outputs.
// CORE_TYPE is shifted back to the MCU during the command byte.
//   clk, reset      : guest clock, synchronous active-high reset
//   spi             : SPI link (slave modport)
//   joystick_0/1    : last payload byte of command 0x02 / 0x03
//   ps2_kbd_*       : keyboard byte plus one-clk valid (command 0x05)
//   ps2_mouse_*     : three mouse bytes plus one-clk valid (command 0x04)
//   status          : last payload byte of command 0x15
module spi_cfg_responder #(
  parameter logic [7:0] CORE_TYPE = 8'hA4
) (
  input  logic                clk,
  input  logic                reset,
  spi_cfg_responder_if.slave  spi,
  output logic [7:0]          joystick_0,
  output logic [7:0]          joystick_1,
  output logic [7:0]          ps2_kbd_data,
  output logic                ps2_kbd_valid,
  output logic [23:0]         ps2_mouse_data,
  output logic                ps2_mouse_valid,
  output logic [7:0]          status
);
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MOUSE_W = 3 * BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_JOY0, ST_JOY1, ST_MOUSE, ST_KBD, ST_STAT, ST_IGNORE
  } state_e;

  logic sck_s1_q, sck_s2_q, sck_s3_q, di_s1_q, di_s2_q, cs_s1_q, cs_s2_q;
  logic sck_s1_d, sck_s2_d, sck_s3_d, di_s1_d, di_s2_d, cs_s1_d, cs_s2_d;
  logic [1:0]          vld_q, vld_d;
  logic                armed_q, armed_d, sel_q, sel_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          shift_q, shift_d;
  logic                first_byte_q, first_byte_d;
  logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
  logic                byte_done_q, byte_done_d;
  logic                do_q, do_d;
  state_e              state_q, state_d;
  logic [1:0]          mouse_cnt_q, mouse_cnt_d;
  logic [15:0]         mouse_stage_q, mouse_stage_d;
  logic [BYTE_W-1:0]   joy0_q, joy0_d, joy1_q, joy1_d, status_q, status_d;
  logic [BYTE_W-1:0]   kbd_data_q, kbd_data_d;
  logic                kbd_valid_q, kbd_valid_d, mouse_valid_q, mouse_valid_d;
  logic [MOUSE_W-1:0]  mouse_data_q, mouse_data_d;

  logic sck_rise_c, sck_fall_c, sel_c, byte_complete_c;

  // Armed only after a genuine deselect has been seen since reset, so a
  // transaction interrupted by reset is ignored until re-select.
  assign sck_rise_c      = sck_s2_q & ~sck_s3_q;
  assign sck_fall_c      = ~sck_s2_q & sck_s3_q;
  assign sel_c           = armed_q & ~cs_s2_q;
  assign byte_complete_c = sck_rise_c & (bit_cnt_q == 3'd7);

  // Synchronisers, bit/byte framing and MISO shifting
  always_comb begin
    sck_s1_d     = spi.SPI_SCK;
    sck_s2_d     = sck_s1_q;
    sck_s3_d     = sck_s2_q;
    di_s1_d      = spi.SPI_DI;
    di_s2_d      = di_s1_q;
    cs_s1_d      = spi.CONF_DATA0;
    cs_s2_d      = cs_s1_q;
    vld_d        = {vld_q[0], 1'b1};
    armed_d      = armed_q | (vld_q[1] & cs_s2_q);
    sel_d        = sel_c;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    first_byte_d = first_byte_q;
    rx_byte_d    = rx_byte_q;
    byte_done_d  = 1'b0;
    do_d         = do_q;
    // Completion is not gated by sel so a byte finishing as sel drops still counts
    if (byte_complete_c) begin
      rx_byte_d   = {shift_q, di_s2_q};
      byte_done_d = 1'b1;
    end
    if (!sel_c) begin
      bit_cnt_d    = 3'd0;
      first_byte_d = 1'b1;
      do_d         = 1'b0;
    end else begin
      if (sck_rise_c) begin
        shift_d   = {shift_q[5:0], di_s2_q};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) first_byte_d = 1'b0;
      end
      // bit_cnt counts bits already taken, so it selects the next MISO bit
      if (!sel_q || sck_fall_c)
        do_d = first_byte_q ? CORE_TYPE[3'd7 - bit_cnt_q] : 1'b0;
    end
  end

  // Command decode and output registers
  always_comb begin
    state_d       = state_q;
    mouse_cnt_d   = mouse_cnt_q;
    mouse_stage_d = mouse_stage_q;
    joy0_d        = joy0_q;
    joy1_d        = joy1_q;
    status_d      = status_q;
    kbd_data_d    = kbd_data_q;
    kbd_valid_d   = 1'b0;
    mouse_data_d  = mouse_data_q;
    mouse_valid_d = 1'b0;
    if (byte_done_q) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_byte_q)
            8'h02:   state_d = ST_JOY0;
            8'h03:   state_d = ST_JOY1;
            8'h04: begin
              state_d     = ST_MOUSE;
              mouse_cnt_d = 2'd0;
            end
            8'h05:   state_d = ST_KBD;
            8'h15:   state_d = ST_STAT;
            default: state_d = ST_IGNORE;
          endcase
        end
        ST_JOY0: joy0_d   = rx_byte_q;
        ST_JOY1: joy1_d   = rx_byte_q;
        ST_STAT: status_d = rx_byte_q;
        ST_KBD: begin
          kbd_data_d  = rx_byte_q;
          kbd_valid_d = 1'b1;
        end
        ST_MOUSE: begin
          if (mouse_cnt_q == 2'd2) begin
            mouse_data_d  = {mouse_stage_q, rx_byte_q};
            mouse_valid_d = 1'b1;
            state_d       = ST_IGNORE;
          end else begin
            mouse_stage_d = {mouse_stage_q[7:0], rx_byte_q};
            mouse_cnt_d   = mouse_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
    // Hold state for one more clk if a byte completes as sel drops
    if (!sel_c && !byte_complete_c) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1_q <= 1'b0; sck_s2_q <= 1'b0; sck_s3_q <= 1'b0;
      di_s1_q  <= 1'b0; di_s2_q  <= 1'b0;
      cs_s1_q  <= 1'b1; cs_s2_q  <= 1'b1;
      vld_q         <= 2'b00;
      armed_q       <= 1'b0;
      sel_q         <= 1'b0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      first_byte_q  <= 1'b1;
      rx_byte_q     <= 8'd0;
      byte_done_q   <= 1'b0;
      do_q          <= 1'b0;
      state_q       <= ST_IDLE;
      mouse_cnt_q   <= 2'd0;
      mouse_stage_q <= 16'd0;
      joy0_q        <= 8'd0;
      joy1_q        <= 8'd0;
      status_q      <= 8'd0;
      kbd_data_q    <= 8'd0;
      kbd_valid_q   <= 1'b0;
      mouse_data_q  <= 24'd0;
      mouse_valid_q <= 1'b0;
    end else begin
      sck_s1_q <= sck_s1_d; sck_s2_q <= sck_s2_d; sck_s3_q <= sck_s3_d;
      di_s1_q  <= di_s1_d;  di_s2_q  <= di_s2_d;
      cs_s1_q  <= cs_s1_d;  cs_s2_q  <= cs_s2_d;
      vld_q         <= vld_d;
      armed_q       <= armed_d;
      sel_q         <= sel_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      first_byte_q  <= first_byte_d;
      rx_byte_q     <= rx_byte_d;
      byte_done_q   <= byte_done_d;
      do_q          <= do_d;
      state_q       <= state_d;
      mouse_cnt_q   <= mouse_cnt_d;
      mouse_stage_q <= mouse_stage_d;
      joy0_q        <= joy0_d;
      joy1_q        <= joy1_d;
      status_q      <= status_d;
      kbd_data_q    <= kbd_data_d;
      kbd_valid_q   <= kbd_valid_d;
      mouse_data_q  <= mouse_data_d;
      mouse_valid_q <= mouse_valid_d;
    end
  end

  assign spi.SPI_DO      = do_q;
  assign joystick_0      = joy0_q;
  assign joystick_1      = joy1_q;
  assign status          = status_q;
  assign ps2_kbd_data    = kbd_data_q;
  assign ps2_kbd_valid   = kbd_valid_q;
  assign ps2_mouse_data  = mouse_data_q;
  assign ps2_mouse_valid = mouse_valid_q;
endmodule

// File: tb/tb_spi_cfg_responder.sv
// Bench for spi_cfg_responder: drives SPI transactions as the MCU would and
// compares outputs against a transaction-level model of the command set.
module tb_spi_cfg_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_cfg_responder_if spi_if ();
  logic [7:0]  joystick_0, joystick_1, ps2_kbd_data, status;
  logic        ps2_kbd_valid, ps2_mouse_valid;
  logic [23:0] ps2_mouse_data;

  spi_cfg_responder #(.CORE_TYPE(8'hA4)) dut (
    .clk(clk), .reset(reset), .spi(spi_if),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .ps2_kbd_data(ps2_kbd_data), .ps2_kbd_valid(ps2_kbd_valid),
    .ps2_mouse_data(ps2_mouse_data), .ps2_mouse_valid(ps2_mouse_valid),
    .status(status)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_joy0, m_joy1, m_status;
  logic [23:0] m_mouse;
  int          m_mouse_n = 0;
  logic [7:0]  exp_kbd[$];
  logic [7:0]  tx_q[$];

  // Monitor state
  int          cyc = 0;
  logic [7:0]  got_kbd[$];
  int          got_mouse = 0;
  int          width_err = 0;
  int          rst_strobe_err = 0;
  logic        kbd_prev = 1'b0, mouse_prev = 1'b0;
  logic [7:0]  joy0_prev = 8'd0;
  int          joy0_chg_cyc = 0;
  int          last_rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2_kbd_valid === 1'b1) begin
      got_kbd.push_back(ps2_kbd_data);
      if (kbd_prev) width_err = width_err + 1;
    end
    if (ps2_mouse_valid === 1'b1) begin
      got_mouse = got_mouse + 1;
      if (mouse_prev) width_err = width_err + 1;
    end
    if (reset && (ps2_kbd_valid || ps2_mouse_valid)) rst_strobe_err = rst_strobe_err + 1;
    kbd_prev   = ps2_kbd_valid;
    mouse_prev = ps2_mouse_valid;
    if (joystick_0 !== joy0_prev) joy0_chg_cyc = cyc;
    joy0_prev = joystick_0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of b MSB first; MISO is sampled just before each rising edge
  task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] miso);
    miso = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_if.SPI_DI = b[3'(7 - i)];
      repeat (4) @(negedge clk);
      miso[3'(7 - i)] = spi_if.SPI_DO;
      spi_if.SPI_SCK = 1'b1;
      last_rise_cyc = cyc;
      repeat (4) @(negedge clk);
      spi_if.SPI_SCK = 1'b0;
    end
  endtask

  // Transaction-level effect of one complete transaction on the outputs
  task automatic model_apply();
    int n;
    n = tx_q.size();
    if (n == 0) return;
    case (tx_q[0])
      8'h02: if (n > 1) m_joy0 = tx_q[n-1];
      8'h03: if (n > 1) m_joy1 = tx_q[n-1];
      8'h15: if (n > 1) m_status = tx_q[n-1];
      8'h05: for (int k = 1; k < n; k++) exp_kbd.push_back(tx_q[k]);
      8'h04: if (n >= 4) begin
        m_mouse = {tx_q[1], tx_q[2], tx_q[3]};
        m_mouse_n++;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".joy0"}, 32'(joystick_0), 32'(m_joy0));
    chk({tag, ".joy1"}, 32'(joystick_1), 32'(m_joy1));
    chk({tag, ".status"}, 32'(status), 32'(m_status));
    chk({tag, ".mouse_data"}, 32'(ps2_mouse_data), 32'(m_mouse));
    chk({tag, ".mouse_strobes"}, 32'(got_mouse), 32'(m_mouse_n));
    chk({tag, ".kbd_count"}, 32'(got_kbd.size()), 32'(exp_kbd.size()));
    for (int k = 0; k < exp_kbd.size() && k < got_kbd.size(); k++)
      chk({tag, ".kbd_byte"}, 32'(got_kbd[k]), 32'(exp_kbd[k]));
    got_kbd.delete();
    exp_kbd.delete();
  endtask

  // One selected transaction of tx_q plus an optional partial trailing byte
  task automatic run_txn(input string tag, input int tail_bits);
    logic [7:0] miso;
    spi_if.CONF_DATA0 = 1'b0;
    repeat (8) @(negedge clk);
    foreach (tx_q[k]) begin
      xfer_bits(tx_q[k], 8, miso);
      if (k == 0) chk({tag, ".miso_cmd"}, 32'(miso), 32'h0000_00A4);
      else        chk({tag, ".miso_data"}, 32'(miso), 32'h0);
    end
    if (tail_bits > 0) xfer_bits(8'($urandom), tail_bits, miso);
    repeat (4) @(negedge clk);
    spi_if.CONF_DATA0 = 1'b1;
    repeat (10) @(negedge clk);
    model_apply();
    compare_all(tag);
  endtask

  initial begin
    logic [7:0] miso;
    logic [7:0] cmd_tab[6];
    int         len;
    cmd_tab[0] = 8'h02; cmd_tab[1] = 8'h03; cmd_tab[2] = 8'h04;
    cmd_tab[3] = 8'h05; cmd_tab[4] = 8'h15; cmd_tab[5] = 8'h00;
    m_joy0 = 8'd0; m_joy1 = 8'd0; m_status = 8'd0; m_mouse = 24'd0;
    reset = 1'b1;
    spi_if.SPI_SCK = 1'b0; spi_if.SPI_DI = 1'b0; spi_if.CONF_DATA0 = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.spi_do", 32'(spi_if.SPI_DO), 32'h0);
    compare_all("rst");
    repeat (100) @(negedge clk);
    chk("idle.spi_do", 32'(spi_if.SPI_DO), 32'h0);
    compare_all("idle");

    tx_q = {8'h02, 8'h5A};
    run_txn("joy0", 0);
    chk("joy0.latency", 32'(joy0_chg_cyc - last_rise_cyc), 32'd4);

    tx_q = {8'h05, 8'hE0, 8'h1C};       run_txn("kbd", 0);
    tx_q = {8'h04, 8'h08, 8'h01, 8'hFF}; run_txn("mouse3", 0);
    tx_q = {8'h04, 8'h12, 8'h34};        run_txn("mouse2", 0);
    tx_q = {8'h15, 8'h80};               run_txn("stat_partial", 4);
    tx_q = {8'h03, 8'h11};               run_txn("joy1_realign", 0);

    // Reset in the middle of a joystick payload; the remainder must be ignored
    spi_if.CONF_DATA0 = 1'b0;
    repeat (8) @(negedge clk);
    xfer_bits(8'h02, 8, miso);
    xfer_bits(8'hA5, 4, miso);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_joy0 = 8'd0; m_joy1 = 8'd0; m_status = 8'd0; m_mouse = 24'd0;
    chk("midrst.joy0", 32'(joystick_0), 32'h0);
    xfer_bits(8'h5A, 4, miso);
    xfer_bits(8'h02, 8, miso);
    xfer_bits(8'h66, 8, miso);
    repeat (4) @(negedge clk);
    spi_if.CONF_DATA0 = 1'b1;
    repeat (10) @(negedge clk);
    compare_all("midrst");

    tx_q = {8'h7F, 8'h33}; run_txn("unknown", 0);

    for (int t = 0; t < 24; t++) begin
      tx_q.delete();
      tx_q.push_back(($urandom_range(0, 5) == 5) ? 8'($urandom) : cmd_tab[$urandom_range(0, 4)]);
      len = $urandom_range(0, 4);
      for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
      run_txn("rand", ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0);
    end

    chk("strobe_width", 32'(width_err), 32'd0);
    chk("strobe_in_reset", 32'(rst_strobe_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
